// File: rtl/music_pkg.sv
// rtl/music_pkg.sv - shared sample width, peak-meter state encodings and folded-sample type
package music_pkg;

  localparam int SAMPLE_W = 16;

  typedef enum logic [1:0] {
    PK_TRACK = 2'd0,
    PK_HOLD  = 2'd1,
    PK_DECAY = 2'd2
  } pk_state_t;

  typedef struct packed {
    logic                area;
    logic [SAMPLE_W-1:0] mag;
  } fold_t;

  // Inverse of the fold; area=1 with mag=0x8000 restores 0x8000 exactly.
  function automatic logic [SAMPLE_W-1:0] restore(input fold_t f);
    return f.area ? (~f.mag + SAMPLE_W'(1)) : f.mag;
  endfunction

endpackage

// File: rtl/peak_meter.sv
// rtl/peak_meter.sv - peak-hold/decay meter over the folded magnitude stream
module peak_meter
  import music_pkg::*;
#(
  parameter int DW          = SAMPLE_W,
  parameter int HOLD_CYCLES = 1024,
  parameter int DECAY_DIV   = 64
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          upd,
  input  logic [DW-1:0] mag,
  input  logic          clear,
  output logic [DW-1:0] peak,
  output logic [1:0]    state
);

  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int VW = (DECAY_DIV > 1) ? $clog2(DECAY_DIV) : 1;
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES - 1);
  localparam logic [VW-1:0] DIV_LOAD  = VW'(DECAY_DIV - 1);

  pk_state_t     st_q, st_d;
  logic [DW-1:0] pk_q, pk_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [VW-1:0] div_q, div_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q   <= PK_TRACK;
      pk_q   <= '0;
      hold_q <= '0;
      div_q  <= '0;
    end else begin
      st_q   <= st_d;
      pk_q   <= pk_d;
      hold_q <= hold_d;
      div_q  <= div_d;
    end
  end

  always_comb begin
    st_d   = st_q;
    pk_d   = pk_q;
    hold_d = hold_q;
    div_d  = div_q;
    if (clear) begin
      st_d   = PK_TRACK;
      pk_d   = '0;
      hold_d = '0;
      div_d  = '0;
    end else if (upd && (mag > pk_q)) begin
      // A strictly larger sample restarts the hold from any state.
      st_d   = PK_HOLD;
      pk_d   = mag;
      hold_d = HOLD_LOAD;
      div_d  = '0;
    end else begin
      case (st_q)
        PK_HOLD: begin
          if (hold_q == '0) begin
            st_d  = PK_DECAY;
            div_d = DIV_LOAD;
          end else begin
            hold_d = hold_q - HW'(1);
          end
        end
        PK_DECAY: begin
          if (pk_q == '0) begin
            st_d  = PK_TRACK;
            div_d = '0;
          end else if (div_q == '0) begin
            pk_d  = pk_q - DW'(1);
            div_d = DIV_LOAD;
            if (pk_q == DW'(1)) begin
              st_d  = PK_TRACK;
              div_d = '0;
            end
          end else begin
            div_d = div_q - VW'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign peak  = pk_q;
  assign state = st_q;

endmodule

// File: rtl/sample_fold.sv
// rtl/sample_fold.sv - sign/magnitude fold with 2-entry buffer and peak meter; SAMPLE_FOLD_SAT_EN saturates 0x8000 to 0x7FFF
module sample_fold
  import music_pkg::*;
#(
  parameter int DW          = SAMPLE_W,
  parameter int HOLD_CYCLES = 1024,
  parameter int DECAY_DIV   = 64
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [DW-1:0] s_data,
  output logic          m_valid,
  input  logic          m_ready,
  output logic          m_area,
  output logic [DW-1:0] m_data,
  input  logic          clear_peak,
  output logic [DW-1:0] peak,
  output logic [1:0]    peak_state
);

  localparam logic [DW-1:0] MOST_NEG = {1'b1, {(DW-1){1'b0}}};
  localparam logic [DW-1:0] MOST_POS = {1'b0, {(DW-1){1'b1}}};

  logic          in_area;
  logic [DW-1:0] in_mag;
  logic [1:0]    count;
  logic          tail_area;
  logic [DW-1:0] tail_mag;
  logic          push;
  logic          pop;

  always_comb begin
    in_area = s_data[DW-1];
    in_mag  = in_area ? (~s_data + DW'(1)) : s_data;
`ifdef SAMPLE_FOLD_SAT_EN
    if (s_data == MOST_NEG) in_mag = MOST_POS;
`else
    // Two's-complement negation of 0x8000 is 0x8000, which restores exactly.
    if (s_data == MOST_NEG) in_mag = MOST_NEG;
`endif
  end

  assign s_ready = (count != 2'd2);
  assign m_valid = (count != 2'd0);
  assign push    = s_valid && s_ready;
  assign pop     = m_valid && m_ready;

  // The head entry lives directly in the m_* registers; the tail only fills when full.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count     <= 2'd0;
      m_area    <= 1'b0;
      m_data    <= '0;
      tail_area <= 1'b0;
      tail_mag  <= '0;
    end else begin
      case (count)
        2'd0: begin
          if (push) begin
            m_area <= in_area;
            m_data <= in_mag;
            count  <= 2'd1;
          end
        end
        2'd1: begin
          if (push && pop) begin
            m_area <= in_area;
            m_data <= in_mag;
          end else if (push) begin
            tail_area <= in_area;
            tail_mag  <= in_mag;
            count     <= 2'd2;
          end else if (pop) begin
            count <= 2'd0;
          end
        end
        2'd2: begin
          if (pop) begin
            m_area <= tail_area;
            m_data <= tail_mag;
            count  <= 2'd1;
          end
        end
        default: count <= 2'd0;
      endcase
    end
  end

  peak_meter #(
    .DW          (DW),
    .HOLD_CYCLES (HOLD_CYCLES),
    .DECAY_DIV   (DECAY_DIV)
  ) u_peak_meter (
    .clk   (clk),
    .rst_n (rst_n),
    .upd   (push),
    .mag   (in_mag),
    .clear (clear_peak),
    .peak  (peak),
    .state (peak_state)
  );

endmodule
